// File: rtl/imuldiv_muldiv_dispatch.sv
// ----------------------------------------------------------------------------
// imuldiv_muldiv_dispatch
//
// Front end for a shared integer multiply/divide datapath. It accepts one
// MUL/DIV/DIVU/REM/REMU request at a time, forwards the registered operands
// to either the multiplier or the divider, waits for that unit's 64-bit
// answer and returns it upstream unmodified. Illegal opcodes, and (when
// BYPASS_DIV0 is set) divisions by zero, are answered locally without
// touching either unit.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   muldivreq_msg_fn/_a/_b      opcode (0 MUL,1 DIV,2 DIVU,3 REM,4 REMU) and operands
//   muldivreq_val/_rdy          upstream request handshake
//   muldivresp_msg_result       64-bit result to upstream
//   muldivresp_val/_rdy         upstream response handshake
//   mulreq_msg_a/_b, _val/_rdy  request to multiplier
//   mulresp_msg_result/_val/_rdy  64-bit product from multiplier
//   divreq_msg_fn/_a/_b, _val/_rdy  request to divider (fn 1 = signed)
//   divresp_msg_result/_val/_rdy    {remainder, quotient} from divider
// ----------------------------------------------------------------------------
module imuldiv_muldiv_dispatch #(
    parameter bit BYPASS_DIV0 = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [2:0]  muldivreq_msg_fn,
    input  logic [31:0] muldivreq_msg_a,
    input  logic [31:0] muldivreq_msg_b,
    input  logic        muldivreq_val,
    output logic        muldivreq_rdy,

    output logic [63:0] muldivresp_msg_result,
    output logic        muldivresp_val,
    input  logic        muldivresp_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy,

    output logic        divreq_msg_fn,
    output logic [31:0] divreq_msg_a,
    output logic [31:0] divreq_msg_b,
    output logic        divreq_val,
    input  logic        divreq_rdy,

    input  logic [63:0] divresp_msg_result,
    input  logic        divresp_val,
    output logic        divresp_rdy
);

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  fn_q, fn_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [63:0] result_q, result_d;

    logic        req_illegal;
    logic        req_div0;
    logic        is_mul_q;

    // Decode of the incoming request, only meaningful in IDLE.
    assign req_illegal = (muldivreq_msg_fn > FN_REMU);
    assign req_div0    = BYPASS_DIV0 && !req_illegal
                         && (muldivreq_msg_fn != FN_MUL)
                         && (muldivreq_msg_b == '0);

    // Only legal opcodes ever reach ISSUE/WAIT, so fn_q is 0..4 there.
    assign is_mul_q = (fn_q == FN_MUL);

    // Operand buses follow the registers; they are only qualified by *_val.
    assign mulreq_msg_a  = a_q;
    assign mulreq_msg_b  = b_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    assign divreq_msg_fn = (fn_q == FN_DIV) || (fn_q == FN_REM);

    assign muldivresp_msg_result = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fn_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        fn_d           = fn_q;
        a_d            = a_q;
        b_d            = b_q;
        result_d       = result_q;
        muldivreq_rdy  = 1'b0;
        muldivresp_val = 1'b0;
        mulreq_val     = 1'b0;
        divreq_val     = 1'b0;
        mulresp_rdy    = 1'b0;
        divresp_rdy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                muldivreq_rdy = 1'b1;
                if (muldivreq_val) begin
                    fn_d = muldivreq_msg_fn;
                    a_d  = muldivreq_msg_a;
                    b_d  = muldivreq_msg_b;
                    if (req_illegal) begin
                        result_d = '0;
                        state_d  = S_RESP;
                    end else if (req_div0) begin
                        // Divide by zero: quotient all ones, remainder = dividend.
                        result_d = {muldivreq_msg_a, 32'hFFFF_FFFF};
                        state_d  = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (is_mul_q) begin
                    mulreq_val = 1'b1;
                    if (mulreq_rdy) state_d = S_WAIT;
                end else begin
                    divreq_val = 1'b1;
                    if (divreq_rdy) state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (is_mul_q) begin
                    mulresp_rdy = 1'b1;
                    if (mulresp_val) begin
                        result_d = mulresp_msg_result;
                        state_d  = S_RESP;
                    end
                end else begin
                    divresp_rdy = 1'b1;
                    if (divresp_val) begin
                        result_d = divresp_msg_result;
                        state_d  = S_RESP;
                    end
                end
            end

            S_RESP: begin
                muldivresp_val = 1'b1;
                if (muldivresp_rdy) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
module tb_imuldiv_muldiv_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  muldivreq_msg_fn;
    logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
    logic        muldivreq_val, muldivreq_rdy;
    logic [63:0] muldivresp_msg_result;
    logic        muldivresp_val, muldivresp_rdy;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy;
    logic [63:0] mulresp_msg_result;
    logic        mulresp_val, mulresp_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a, divreq_msg_b;
    logic        divreq_val, divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val, divresp_rdy;

    always #5 clk = ~clk;

    imuldiv_muldiv_dispatch #(.BYPASS_DIV0(1'b1)) dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
        .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b),
        .mulreq_val(mulreq_val), .mulreq_rdy(mulreq_rdy),
        .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
        .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a),
        .divreq_msg_b(divreq_msg_b), .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        bit          is_mul;
        bit          is_div;
        bit          bypass;
        int          fire_cyc;
    } exp_t;
    exp_t exp_q[$];

    // Unit stub knobs (-1 = random) and what the stubs actually used.
    int mul_stall_force = -1, mul_lat_force = -1;
    int div_stall_force = -1, div_lat_force = -1;
    int last_mul_stall = 0, last_mul_lat = 0;
    int last_div_stall = 0, last_div_lat = 0;
    bit resp_block = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of each opcode.
    function automatic logic [63:0] ref_result(input logic [2:0] fn,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sbv, q, r;
        case (fn)
            3'd0: return 64'(a) * 64'(b);
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (fn == 3'd1 || fn == 3'd3) begin
                    sa = a; sbv = b; q = sa / sbv; r = sa % sbv;
                    return {r, q};
                end
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- multiplier stub ----------------
    initial begin : mul_stub
        logic [31:0] ca, cb;
        int st, lt, n;
        mulreq_rdy = 1'b0; mulresp_val = 1'b0; mulresp_msg_result = '0;
        forever begin
            @(negedge clk);
            if (mulreq_val && !reset) begin
                ca = mulreq_msg_a; cb = mulreq_msg_b;
                st = (mul_stall_force >= 0) ? mul_stall_force : int'($urandom_range(0, 2));
                lt = (mul_lat_force >= 0) ? mul_lat_force : int'($urandom_range(0, 4));
                for (int i = 0; i < st; i++) begin
                    @(negedge clk);
                    chk("mul_issue_val_hold", 64'(mulreq_val), 64'd1);
                    chk("mul_issue_a_hold", 64'(mulreq_msg_a), 64'(ca));
                    chk("mul_issue_b_hold", 64'(mulreq_msg_b), 64'(cb));
                end
                mulreq_rdy = 1'b1;
                @(negedge clk);
                mulreq_rdy = 1'b0;
                last_mul_stall = st; last_mul_lat = lt;
                repeat (lt) @(negedge clk);
                mulresp_msg_result = 64'(ca) * 64'(cb);
                mulresp_val = 1'b1;
                n = 0;
                while (!mulresp_rdy && n < 100) begin @(negedge clk); n++; end
                if (n >= 100) chk("mul_resp_rdy_timeout", 64'(mulresp_rdy), 64'd1);
                @(negedge clk);
                mulresp_val = 1'b0;
            end
        end
    end

    // ---------------- divider stub ----------------
    initial begin : div_stub
        logic [31:0] ca, cb;
        logic        cfn;
        logic signed [31:0] sq, sr;
        int st, lt, n;
        bit abort;
        divreq_rdy = 1'b0; divresp_val = 1'b0; divresp_msg_result = '0;
        forever begin
            @(negedge clk);
            if (divreq_val && !reset) begin
                ca = divreq_msg_a; cb = divreq_msg_b; cfn = divreq_msg_fn;
                st = (div_stall_force >= 0) ? div_stall_force : int'($urandom_range(0, 2));
                lt = (div_lat_force >= 0) ? div_lat_force : int'($urandom_range(0, 4));
                for (int i = 0; i < st; i++) begin
                    @(negedge clk);
                    chk("div_issue_val_hold", 64'(divreq_val), 64'd1);
                    chk("div_issue_a_hold", 64'(divreq_msg_a), 64'(ca));
                    chk("div_issue_b_hold", 64'(divreq_msg_b), 64'(cb));
                    chk("div_issue_no_accept", 64'(muldivreq_rdy), 64'd0);
                end
                divreq_rdy = 1'b1;
                @(negedge clk);
                divreq_rdy = 1'b0;
                last_div_stall = st; last_div_lat = lt;
                abort = 1'b0;
                for (int i = 0; i < lt; i++) begin
                    @(negedge clk);
                    if (reset) begin abort = 1'b1; break; end
                end
                if (abort) begin
                    // Answer arriving after the dispatcher was reset must be ignored.
                    while (reset) @(negedge clk);
                    divresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D;
                    divresp_val = 1'b1;
                    chk("stale_divresp_rdy", 64'(divresp_rdy), 64'd0);
                    @(negedge clk);
                    divresp_val = 1'b0;
                end else begin
                    if (cb == 32'd0) divresp_msg_result = '1;
                    else if (cfn) begin
                        sq = $signed(ca) / $signed(cb); sr = $signed(ca) % $signed(cb);
                        divresp_msg_result = {sr, sq};
                    end else divresp_msg_result = {ca % cb, ca / cb};
                    divresp_val = 1'b1;
                    n = 0;
                    while (!divresp_rdy && n < 100) begin @(negedge clk); n++; end
                    if (n >= 100) chk("div_resp_rdy_timeout", 64'(divresp_rdy), 64'd1);
                    @(negedge clk);
                    divresp_val = 1'b0;
                end
            end
        end
    end

    // ---------------- upstream response acceptor ----------------
    initial begin
        muldivresp_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            muldivresp_rdy = resp_block ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int mul_hi, div_hi, mrdy_hi, drdy_hi, first_cyc;
        bit prev_val, prev_fire, fire;
        logic [63:0] prev_res;
        exp_t e;
        mul_hi = 0; div_hi = 0; mrdy_hi = 0; drdy_hi = 0; first_cyc = 0;
        prev_val = 0; prev_fire = 0; prev_res = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mul_hi = 0; div_hi = 0; mrdy_hi = 0; drdy_hi = 0;
                prev_val = 0; prev_fire = 0;
            end else begin
                if (mulreq_val)  mul_hi++;
                if (divreq_val)  div_hi++;
                if (mulresp_rdy) mrdy_hi++;
                if (divresp_rdy) drdy_hi++;
                if (prev_val && !prev_fire) begin
                    chk("resp_val_hold", 64'(muldivresp_val), 64'd1);
                    chk("resp_result_hold", muldivresp_msg_result, prev_res);
                end
                if (muldivresp_val) begin
                    chk("no_accept_during_resp", 64'(muldivreq_rdy), 64'd0);
                    if (!prev_val) first_cyc = cyc;
                end
                fire = muldivresp_val && muldivresp_rdy;
                if (fire) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", muldivresp_msg_result, e.res);
                        chk("mulreq_val_cycles", 64'(mul_hi), e.is_mul ? 64'(last_mul_stall + 1) : 64'd0);
                        chk("divreq_val_cycles", 64'(div_hi), e.is_div ? 64'(last_div_stall + 1) : 64'd0);
                        chk("mulresp_rdy_cycles", 64'(mrdy_hi), e.is_mul ? 64'(last_mul_lat + 1) : 64'd0);
                        chk("divresp_rdy_cycles", 64'(drdy_hi), e.is_div ? 64'(last_div_lat + 1) : 64'd0);
                        if (e.bypass) chk("bypass_latency", 64'(first_cyc - e.fire_cyc), 64'd1);
                    end
                    mul_hi = 0; div_hi = 0; mrdy_hi = 0; drdy_hi = 0;
                end
                prev_val  = muldivresp_val;
                prev_res  = muldivresp_msg_result;
                prev_fire = fire;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int n;
        muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
        muldivreq_val = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!muldivreq_rdy && n < 500);
        if (!muldivreq_rdy) chk("req_accept_timeout", 64'(muldivreq_rdy), 64'd1);
        else begin
            e.res      = ref_result(fn, a, b);
            e.is_mul   = (fn == 3'd0);
            e.is_div   = (fn >= 3'd1) && (fn <= 3'd4) && (b != 32'd0);
            e.bypass   = (fn > 3'd4) || ((fn != 3'd0) && (b == 32'd0));
            e.fire_cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        muldivreq_val = 1'b0;
        muldivreq_msg_fn = 3'($urandom); muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_muldivreq_rdy", 64'(muldivreq_rdy), 64'd1);
        chk("rst_muldivresp_val", 64'(muldivresp_val), 64'd0);
        chk("rst_mulreq_val", 64'(mulreq_val), 64'd0);
        chk("rst_divreq_val", 64'(divreq_val), 64'd0);
        chk("rst_mulresp_rdy", 64'(mulresp_rdy), 64'd0);
        chk("rst_divresp_rdy", 64'(divresp_rdy), 64'd0);
        chk("rst_result", muldivresp_msg_result, 64'd0);
        chk("rst_a_reg", 64'(mulreq_msg_a), 64'd0);
        chk("rst_b_reg", 64'(divreq_msg_b), 64'd0);
        chk("rst_fn_reg", 64'(divreq_msg_fn), 64'd0);
    endtask

    initial begin : driver
        int r;
        logic [2:0]  fn;
        logic [31:0] a, b;
        reset = 1'b1;
        muldivreq_val = 1'b0; muldivreq_msg_fn = '0; muldivreq_msg_a = '0; muldivreq_msg_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        // MUL 7*6, unit answers 3 cycles after accepting.
        mul_stall_force = 0; mul_lat_force = 3;
        send(3'd0, 32'd7, 32'd6);
        drain();
        mul_stall_force = -1; mul_lat_force = -1;

        // Signed DIV -7/2.
        send(3'd1, 32'hFFFF_FFF9, 32'd2);
        drain();

        // DIVU by zero: answered locally.
        send(3'd2, 32'd5, 32'd0);
        drain();

        // Divider refuses the request for 4 cycles.
        div_stall_force = 4;
        send(3'd3, 32'd100, 32'd7);
        drain();
        div_stall_force = -1;

        // Upstream stalls the response; a new request must wait.
        resp_block = 1'b1;
        send(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        r = 0;
        while (!muldivresp_val && r < 50) begin @(negedge clk); r++; end
        chk("resp_appears", 64'(muldivresp_val), 64'd1);
        @(posedge clk); #1;
        muldivreq_msg_fn = 3'd2; muldivreq_msg_a = 32'd9; muldivreq_msg_b = 32'd2; muldivreq_val = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("blocked_req_rdy", 64'(muldivreq_rdy), 64'd0);
        end
        @(posedge clk); #1;
        resp_block = 1'b0;
        send(3'd2, 32'd9, 32'd2);
        drain();

        // Reset while the divider is working, then its stale answer.
        div_stall_force = 0; div_lat_force = 30;
        send(3'd1, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        repeat (4) begin
            @(negedge clk);
            chk("post_reset_no_resp", 64'(muldivresp_val), 64'd0);
            chk("post_reset_divresp_rdy", 64'(divresp_rdy), 64'd0);
        end
        @(posedge clk); #1;
        div_stall_force = -1; div_lat_force = -1;
        send(3'd6, $urandom, $urandom);
        drain();

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      fn = 3'd0;
            else if (r < 8) fn = 3'($urandom_range(1, 4));
            else            fn = 3'($urandom_range(5, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            send(fn, a, b);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
IMULDIV_MULDIV_DISPATCH -- requirements
Module: imuldiv_muldiv_dispatch

Interface
REQ-001 The block SHALL have one parameter: BYPASS_DIV0, default 1; when 1, divide/remainder by zero is answered locally without issuing to the divider.
REQ-002 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk in 1 clock
- reset in 1 sync active-high reset
- muldivreq_msg_fn in 3 op: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal
- muldivreq_msg_a in 32 operand A
- muldivreq_msg_b in 32 operand B
- muldivreq_val in 1 upstream request valid
- muldivreq_rdy out 1 request accepted when val&rdy
- muldivresp_msg_result out 64 result to upstream
- muldivresp_val out 1 response valid
- muldivresp_rdy in 1 upstream takes response
- mulreq_msg_a / mulreq_msg_b out 32 each, operands to multiplier
- mulreq_val out 1, mulreq_rdy in 1
- mulresp_msg_result in 64 product
- mulresp_val in 1, mulresp_rdy out 1
- divreq_msg_fn out 1 (1 signed, 0 unsigned)
- divreq_msg_a / divreq_msg_b out 32 each, operands to divider
- divreq_val out 1, divreq_rdy in 1
- divresp_msg_result in 64 {remainder[63:32], quotient[31:0]}
- divresp_val in 1, divresp_rdy out 1

Function
REQ-004 The block SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with at most one operation outstanding.
REQ-005 In IDLE, muldivreq_rdy SHALL be 1; in all other states, 0.
REQ-006 On request fire in IDLE, the block SHALL register fn, a, b, and SHALL go to ISSUE, or to RESP on a bypass (REQ-011/REQ-012).
REQ-007 In ISSUE, the block SHALL drive registered operands to the selected unit and SHALL assert only that unit's req_val:
- mulreq_val for fn 0
- divreq_val for fn 1-4, with divreq_msg_fn = 1 for fn 1 and 3, 0 for fn 2 and 4.
REQ-008 In ISSUE, the block SHALL hold val and operands stable until the unit's req_rdy is 1, then go to WAIT.
REQ-009 In WAIT, the block SHALL assert resp_rdy only toward the selected unit; on that unit's resp_val it SHALL capture the 64-bit result and go to RESP.
REQ-010 Captured results SHALL be passed unmodified: MUL gives the full 64-bit product, DIV/REM gives {rem, quot}.
REQ-011 With BYPASS_DIV0=1, fn 1-4 with b==0 SHALL skip ISSUE/WAIT: the result SHALL be {a, 32'hFFFFFFFF} and the next state RESP.
REQ-012 Illegal fn (5-7) SHALL skip ISSUE/WAIT, with result 64'h0 and next state RESP.
REQ-013 In RESP, muldivresp_val SHALL be 1 and the result SHALL be held stable; on muldivresp_rdy the next state SHALL be IDLE.
REQ-014 No new request SHALL be accepted in the cycle a response fires; the minimum occupancy is 2 cycles.
REQ-015 Latency (cycles from request fire to muldivresp_val):
- bypass: 1
- issued op: 1 (ISSUE) + unit req stall + unit latency + 1.
REQ-016 resp_val from the non-selected unit, or from either unit outside WAIT, SHALL be ignored and not acknowledged.
REQ-017 mulresp_rdy and divresp_rdy SHALL be 0 outside WAIT.
REQ-018 mulreq_val and divreq_val SHALL be 0 outside ISSUE.
REQ-019 Sub-unit operand outputs MAY carry stale data when their val is 0.

Reset
REQ-020 With reset high at a clock edge, the state SHALL become IDLE from any state, including mid-ISSUE, WAIT or RESP; any in-flight result SHALL be discarded.
REQ-021 Cycle after reset, outputs SHALL be:
- muldivreq_rdy 1
- muldivresp_val, mulreq_val, divreq_val, mulresp_rdy, divresp_rdy 0
- muldivresp_msg_result 64'h0
- internal fn/a/b registers 0

Verification
REQ-022 The bench SHALL cover these scenarios:
- MUL a=7, b=6, unit returns 64'd42 after 3 cycles -> muldivresp_msg_result=64'd42; mulreq_val high exactly 1 cycle; divreq_val never 1.
- DIV a=-7, b=2 -> divreq_msg_fn=1 and operands unchanged; stub result {32'hFFFFFFFF, 32'hFFFFFFFD} -> passed through unchanged.
- DIVU a=5, b=0 -> muldivresp_val 1 cycle after fire, result {32'h5, 32'hFFFFFFFF}; divreq_val never 1.
- divreq_rdy held 0 for 4 cycles in ISSUE -> divreq_val, a, b stable throughout; muldivreq_rdy 0 throughout.
- muldivresp_rdy held 0 for 3 cycles in RESP -> result and val stable; new muldivreq_val ignored until IDLE.
- Reset asserted in WAIT, then stale divresp_val pulse in IDLE -> muldivreq_rdy 1, divresp_rdy 0, no response produced; illegal fn=6 -> result 64'h0.
